// File: rtl/pid_pkg.sv
// Shared types and sizing helpers for the sequential PID controller.
package pid_pkg;

  // One state per use of the shared multiplier, plus the final sum/saturate step.
  typedef enum logic [2:0] {
    IDLE,
    MUL_P,
    MUL_I,
    MUL_D,
    SUM
  } state_t;

  // Guard bits above DATA_W+GAIN_W so that P + I + D can never wrap.
  localparam int ACC_HEADROOM = 4;

  function automatic bit acc_w_ok(input int acc_w, input int data_w, input int gain_w);
    return acc_w >= data_w + gain_w + ACC_HEADROOM;
  endfunction

endpackage

// File: rtl/pid_saturate.sv
// Signed clip of an IN_W value into [MIN, MAX], narrowed to OUT_W bits,
// with flags telling which limit was hit.
module pid_saturate #(
  parameter int     IN_W  = 40,
  parameter int     OUT_W = 16,
  parameter longint MAX   = 32767,
  parameter longint MIN   = -32768
) (
  input  logic signed [IN_W-1:0]  i_val,
  output logic signed [OUT_W-1:0] o_val,
  output logic                    o_hi,
  output logic                    o_lo
);

  localparam logic signed [IN_W-1:0] LIM_HI = IN_W'(MAX);
  localparam logic signed [IN_W-1:0] LIM_LO = IN_W'(MIN);

  // Compare at full width, then narrow; the limits always fit in OUT_W.
  always_comb begin
    o_hi = (i_val > LIM_HI);
    o_lo = (i_val < LIM_LO);
    if (o_hi) begin
      o_val = LIM_HI[OUT_W-1:0];
    end else if (o_lo) begin
      o_val = LIM_LO[OUT_W-1:0];
    end else begin
      o_val = i_val[OUT_W-1:0];
    end
  end

endmodule

// File: rtl/pid_controller_seq.sv
// Sequential signed PID controller: one accepted sample produces one control
// update five cycles later, using a single multiplier shared by P, I and D.
module pid_controller_seq
  import pid_pkg::*;
#(
  parameter int DATA_W  = 16,
  parameter int GAIN_W  = 16,
  parameter int FRAC_W  = 8,
  parameter int ACC_W   = 40,
  parameter int INT_LIM = 2 ** 20,
  parameter int OUT_MIN = -(2 ** (DATA_W - 1)),
  parameter int OUT_MAX = (2 ** (DATA_W - 1)) - 1
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [DATA_W-1:0] setpoint,
  input  logic signed [DATA_W-1:0] process_value,
  input  logic        [GAIN_W-1:0] kp,
  input  logic        [GAIN_W-1:0] ki,
  input  logic        [GAIN_W-1:0] kd,
  input  logic                     integ_clr,
  output logic                     out_valid,
  output logic signed [DATA_W-1:0] control_output,
  output logic                     sat_hi,
  output logic                     sat_lo
);

  localparam int EXT_E = ACC_W - DATA_W - 1;
  localparam int EXT_D = ACC_W - DATA_W - 2;
  localparam int EXT_G = ACC_W - GAIN_W;

  if (!acc_w_ok(ACC_W, DATA_W, GAIN_W)) begin : g_acc_w_check
    $error("pid_controller_seq: ACC_W too narrow for DATA_W + GAIN_W");
  end

  state_t                    r_state, w_next;
  logic signed [DATA_W:0]    r_err, r_prev_err;
  logic        [GAIN_W-1:0]  r_kp, r_ki, r_kd;
  logic signed [ACC_W-1:0]   r_acc, r_integral;
  logic signed [DATA_W-1:0]  r_out;
  logic                      r_sat_hi, r_sat_lo, r_out_valid;

  logic                      w_accept, w_skip;
  logic signed [DATA_W+1:0]  w_d;
  logic signed [ACC_W-1:0]   w_err_ext, w_d_ext, w_int_sum, w_int_clip, w_int_new;
  logic signed [ACC_W-1:0]   w_mul_a, w_mul_b, w_prod, w_shifted;
  logic signed [DATA_W-1:0]  w_out;
  logic                      w_int_hi, w_int_lo, w_out_hi, w_out_lo;

  // Drop FRAC_W fraction bits; arithmetic shift rounds toward -inf.
  function automatic logic signed [ACC_W-1:0] floor_shift(input logic signed [ACC_W-1:0] v);
    return v >>> FRAC_W;
  endfunction

  assign w_accept  = in_valid && in_ready;
  assign w_err_ext = {{EXT_E{r_err[DATA_W]}}, r_err};
  assign w_d       = {r_err[DATA_W], r_err} - {r_prev_err[DATA_W], r_prev_err};
  assign w_d_ext   = {{EXT_D{w_d[DATA_W+1]}}, w_d};
  // Anti-windup: do not push the integrator further into a saturated output.
  assign w_skip    = (r_sat_hi && !r_err[DATA_W] && (r_err != '0)) || (r_sat_lo && r_err[DATA_W]);
  assign w_int_sum = w_skip ? r_integral : r_integral + w_err_ext;
  assign w_int_new = (w_int_hi || w_int_lo) ? w_int_clip : w_int_sum;
  assign w_prod    = w_mul_a * w_mul_b;
  assign w_shifted = floor_shift(r_acc);

  pid_saturate #(
    .IN_W (ACC_W),
    .OUT_W(ACC_W),
    .MAX  (INT_LIM),
    .MIN  (-INT_LIM)
  ) u_int_clamp (
    .i_val(w_int_sum),
    .o_val(w_int_clip),
    .o_hi (w_int_hi),
    .o_lo (w_int_lo)
  );

  pid_saturate #(
    .IN_W (ACC_W),
    .OUT_W(DATA_W),
    .MAX  (OUT_MAX),
    .MIN  (OUT_MIN)
  ) u_out_sat (
    .i_val(w_shifted),
    .o_val(w_out),
    .o_hi (w_out_hi),
    .o_lo (w_out_lo)
  );

  // State register; reset aborts any update in flight.
  always_ff @(posedge clock) begin
    if (!reset_n) r_state <= IDLE;
    else          r_state <= w_next;
  end

  // Fixed walk through the multiplier slots once a sample is taken.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_next = MUL_P;
      MUL_P:   w_next = MUL_I;
      MUL_I:   w_next = MUL_D;
      MUL_D:   w_next = SUM;
      SUM:     w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Handshake and shared-multiplier operand selection per state.
  always_comb begin
    in_ready = reset_n && (r_state == IDLE);
    w_mul_a  = {{EXT_G{1'b0}}, r_kp};
    w_mul_b  = w_err_ext;
    case (r_state)
      MUL_I: begin
        w_mul_a = {{EXT_G{1'b0}}, r_ki};
        w_mul_b = w_int_new;
      end
      MUL_D: begin
        w_mul_a = {{EXT_G{1'b0}}, r_kd};
        w_mul_b = w_d_ext;
      end
      default: ;
    endcase
  end

  // Controller state and outputs: integrator, previous error, result and flags.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_integral  <= '0;
      r_prev_err  <= '0;
      r_out       <= '0;
      r_sat_hi    <= 1'b0;
      r_sat_lo    <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      r_out_valid <= (r_state == SUM);
      if (w_accept && integ_clr) begin
        r_integral <= '0;
        r_prev_err <= '0;
      end
      if (r_state == MUL_I) r_integral <= w_int_new;
      if (r_state == SUM) begin
        r_out      <= w_out;
        r_sat_hi   <= w_out_hi;
        r_sat_lo   <= w_out_lo;
        r_prev_err <= r_err;
      end
    end
  end

  // Sample capture and product accumulation; pure data, no reset needed.
  always_ff @(posedge clock) begin
    if (w_accept) begin
      r_err <= {setpoint[DATA_W-1], setpoint} - {process_value[DATA_W-1], process_value};
      r_kp  <= kp;
      r_ki  <= ki;
      r_kd  <= kd;
    end
    case (r_state)
      MUL_P:        r_acc <= w_prod;
      MUL_I, MUL_D: r_acc <= r_acc + w_prod;
      default:      r_acc <= r_acc;
    endcase
  end

  assign out_valid      = r_out_valid;
  assign control_output = r_out;
  assign sat_hi         = r_sat_hi;
  assign sat_lo         = r_sat_lo;

endmodule

// File: tb/tb_pid_controller_seq.sv
// Scoreboard bench for pid_controller_seq: expected updates are queued when a
// sample is accepted and compared when out_valid fires.
module tb_pid_controller_seq;

  localparam int DATA_W  = 16;
  localparam int GAIN_W  = 16;
  localparam int FRAC_W  = 8;
  localparam int ACC_W   = 40;
  localparam int INT_LIM = 500;
  localparam int OUT_MIN = -64;
  localparam int OUT_MAX = 1000;

  logic                     clock = 1'b0;
  logic                     reset_n = 1'b0;
  logic                     in_valid = 1'b0;
  logic                     integ_clr = 1'b0;
  logic signed [DATA_W-1:0] setpoint = '0;
  logic signed [DATA_W-1:0] process_value = '0;
  logic        [GAIN_W-1:0] kp = '0, ki = '0, kd = '0;
  logic                     in_ready, out_valid, sat_hi, sat_lo;
  logic signed [DATA_W-1:0] control_output;

  pid_controller_seq #(
    .DATA_W(DATA_W), .GAIN_W(GAIN_W), .FRAC_W(FRAC_W), .ACC_W(ACC_W),
    .INT_LIM(INT_LIM), .OUT_MIN(OUT_MIN), .OUT_MAX(OUT_MAX)
  ) dut (
    .clock(clock), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .setpoint(setpoint), .process_value(process_value),
    .kp(kp), .ki(ki), .kd(kd), .integ_clr(integ_clr),
    .out_valid(out_valid), .control_output(control_output),
    .sat_hi(sat_hi), .sat_lo(sat_lo)
  );

  always #5 clock = ~clock;

  longint cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    longint val;
    logic   hi;
    logic   lo;
    longint acc_cyc;
  } exp_t;

  exp_t   sb[$];
  longint acc_log[$];

  // Reference controller state
  longint m_int = 0, m_prev = 0;
  logic   m_hi = 1'b0, m_lo = 1'b0;

  task automatic check_val(input string tag, input longint obs, input longint exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic exp_t model(input longint sp, input longint pv, input longint gp,
                                 input longint gi, input longint gd, input logic clr,
                                 input longint c);
    exp_t   r;
    longint e, pp, pi, pd, s;
    e = sp - pv;
    if (clr) begin
      m_int  = 0;
      m_prev = 0;
    end
    pp = gp * e;
    if (!((m_hi && e > 0) || (m_lo && e < 0))) begin
      m_int = m_int + e;
      if (m_int > INT_LIM) m_int = INT_LIM;
      else if (m_int < -INT_LIM) m_int = -INT_LIM;
    end
    pi = gi * m_int;
    pd = gd * (e - m_prev);
    s  = (pp + pi + pd) >>> FRAC_W;
    r.hi = (s > OUT_MAX);
    r.lo = (s < OUT_MIN);
    r.val = r.hi ? longint'(OUT_MAX) : (r.lo ? longint'(OUT_MIN) : s);
    r.acc_cyc = c;
    m_hi   = r.hi;
    m_lo   = r.lo;
    m_prev = e;
    return r;
  endfunction

  // Monitor: retire outputs against the scoreboard, then log new accepts.
  always @(negedge clock) begin : monitor
    exp_t x;
    if (reset_n && out_valid) begin
      if (sb.size() == 0) begin
        check_val("spurious_out_valid", 1, 0);
      end else begin
        x = sb.pop_front();
        check_val("control_output", control_output, x.val);
        check_val("sat_hi", sat_hi, x.hi);
        check_val("sat_lo", sat_lo, x.lo);
        check_val("latency", cyc - x.acc_cyc, 5);
        check_val("ready_overlap", in_ready, 1);
      end
    end
    if (reset_n && in_valid && in_ready) begin
      sb.push_back(model(longint'(setpoint), longint'(process_value), longint'(kp),
                         longint'(ki), longint'(kd), integ_clr, cyc));
      acc_log.push_back(cyc);
    end
  end

  task automatic send(input int sp, input int pv, input logic [GAIN_W-1:0] gp,
                      input logic [GAIN_W-1:0] gi, input logic [GAIN_W-1:0] gd,
                      input logic clr);
    int n = 0;
    @(posedge clock); #1;
    while (!in_ready && n < 40) begin
      @(posedge clock); #1;
      n++;
    end
    if (!in_ready) check_val("ready_timeout", 0, 1);
    setpoint      = DATA_W'(sp);
    process_value = DATA_W'(pv);
    kp = gp; ki = gi; kd = gd;
    integ_clr = clr;
    in_valid  = 1'b1;
    @(posedge clock); #1;
    in_valid  = 1'b0;
    integ_clr = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 60) begin
      @(posedge clock); #1;
      n++;
    end
    if (sb.size() != 0) check_val("drain_timeout", sb.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset state
    repeat (3) @(posedge clock);
    #1;
    check_val("rst_in_ready", in_ready, 0);
    check_val("rst_out_valid", out_valid, 0);
    check_val("rst_output", control_output, 0);
    check_val("rst_sat_hi", sat_hi, 0);
    check_val("rst_sat_lo", sat_lo, 0);
    reset_n = 1'b1;
    #1;
    check_val("ready_after_reset", in_ready, 1);

    // Proportional: 100 - 40 with gain 1.0
    send(100, 40, 16'h0100, 16'h0000, 16'h0000, 1'b1);
    drain();

    // Integral accumulates, then integ_clr restarts it
    send(10, 0, 16'h0000, 16'h0100, 16'h0000, 1'b1);
    send(10, 0, 16'h0000, 16'h0100, 16'h0000, 1'b0);
    send(10, 0, 16'h0000, 16'h0100, 16'h0000, 1'b0);
    send(10, 0, 16'h0000, 16'h0100, 16'h0000, 1'b1);
    drain();

    // Derivative, then fractional gain with floor rounding
    send(5, 0, 16'h0000, 16'h0000, 16'h0100, 1'b1);
    send(20, 0, 16'h0000, 16'h0000, 16'h0100, 1'b0);
    send(3, 0, 16'h0080, 16'h0000, 16'h0000, 1'b0);
    send(0, 3, 16'h0080, 16'h0000, 16'h0000, 1'b0);
    drain();

    // Output saturation at both limits
    send(2000, 0, 16'h0100, 16'h0000, 16'h0000, 1'b0);
    send(0, 100, 16'h0100, 16'h0000, 16'h0000, 1'b0);
    drain();

    // Integrator clamp at INT_LIM
    send(400, 0, 16'h0000, 16'h0100, 16'h0000, 1'b1);
    send(400, 0, 16'h0000, 16'h0100, 16'h0000, 1'b0);
    drain();

    // Anti-windup: integral frozen while sat_hi and e > 0, then read back at gain 1.0
    send(300, 0, 16'h0000, 16'h0400, 16'h0000, 1'b1);
    send(50, 0, 16'h0000, 16'h0400, 16'h0000, 1'b0);
    send(0, 0, 16'h0000, 16'h0100, 16'h0000, 1'b0);
    drain();

    // in_valid held high: accepts every fifth cycle only
    @(posedge clock); #1;
    acc_log.delete();
    setpoint = 17; process_value = 10;
    kp = 16'h0100; ki = '0; kd = '0; integ_clr = 1'b0;
    in_valid = 1'b1;
    repeat (11) @(posedge clock);
    #1;
    in_valid = 1'b0;
    check_val("accept_count", acc_log.size(), 3);
    if (acc_log.size() >= 3) begin
      check_val("accept_gap_1", acc_log[1] - acc_log[0], 5);
      check_val("accept_gap_2", acc_log[2] - acc_log[1], 5);
    end
    drain();

    // Random samples against the reference model
    for (int i = 0; i < 10; i++) begin
      send(int'($urandom_range(0, 1000)) - 500, int'($urandom_range(0, 1000)) - 500,
           GAIN_W'($urandom_range(0, 512)), GAIN_W'($urandom_range(0, 512)),
           GAIN_W'($urandom_range(0, 512)), 1'($urandom_range(0, 1)));
    end
    drain();
    send(17, 10, 16'h0100, 16'h0000, 16'h0000, 1'b0);
    drain();

    // Reset during MUL_I aborts the update
    send(60, 0, 16'h0100, 16'h0100, 16'h0000, 1'b0);
    @(posedge clock); #1;
    reset_n = 1'b0;
    sb.delete();
    m_int = 0; m_prev = 0; m_hi = 1'b0; m_lo = 1'b0;
    @(posedge clock); #1;
    check_val("abort_output", control_output, 0);
    check_val("abort_in_ready", in_ready, 0);
    check_val("abort_out_valid", out_valid, 0);
    check_val("abort_sat_hi", sat_hi, 0);
    @(posedge clock); #1;
    reset_n = 1'b1;
    #1;
    check_val("abort_ready_after", in_ready, 1);
    repeat (8) @(posedge clock);
    #1;
    // Integrator must have been cleared by the reset
    send(10, 0, 16'h0000, 16'h0100, 16'h0000, 1'b0);
    drain();

    check_val("scoreboard_empty", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
